// File: rtl/fp_addsub_arbiter_pkg.sv
// rtl/fp_addsub_arbiter_pkg.sv - shared constants, FSM encoding and sign helper for the FP add/sub arbiter
package fp_addsub_arbiter_pkg;

  localparam logic [31:0] FP_ONE  = 32'h3F800000;
  localparam logic [31:0] FP_QNAN = 32'h7FC00000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  function automatic logic [31:0] fp_negate(input logic [31:0] v);
    return {~v[31], v[30:0]};
  endfunction

endpackage

// File: rtl/fp_addsub_arbiter_rr_pick.sv
// rtl/fp_addsub_arbiter_rr_pick.sv - combinational round-robin picker: first request above i_ptr, with wrap
module fp_addsub_arbiter_rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_ptr,
  output logic [N-1:0]         o_grant,
  output logic [$clog2(N)-1:0] o_idx,
  output logic                 o_valid
);

  localparam int IW = $clog2(N);

  always_comb begin
    int j;
    j       = 0;
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    // k = N revisits i_ptr itself last, so a lone requester always wins
    for (int k = 1; k <= N; k++) begin
      j = int'(i_ptr) + k;
      if (j >= N) j = j - N;
      if (!o_valid && i_req[IW'(j)]) begin
        o_valid           = 1'b1;
        o_idx             = IW'(j);
        o_grant[IW'(j)]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_addsub_arbiter.sv
// rtl/fp_addsub_arbiter.sv - round-robin sharing of one multi-cycle FP add/sub core with a hang watchdog
module fp_addsub_arbiter
  import fp_addsub_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [NUM_REQ-1:0]    i_req,
  input  logic [NUM_REQ-1:0]    i_req_sub,
  input  logic [32*NUM_REQ-1:0] i_req_a,
  input  logic [32*NUM_REQ-1:0] i_req_b,
  output logic [NUM_REQ-1:0]    o_grant,
  output logic [NUM_REQ-1:0]    o_done,
  output logic [31:0]           o_result,
  output logic                  o_error,
  output logic                  o_busy,
  output logic                  o_core_start,
  output logic [31:0]           o_core_a,
  output logic [31:0]           o_core_b,
  input  logic                  i_core_done,
  input  logic [31:0]           i_core_result
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int WW = $clog2(TIMEOUT + 1);

  state_t          r_state;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_idx;
  logic [31:0]     r_a_lat;
  logic [31:0]     r_b_lat;
  logic [WW-1:0]   r_wdog;

  logic [NUM_REQ-1:0] w_pick_grant;
  logic [IW-1:0]      w_pick_idx;
  logic               w_pick_valid;
  logic [31:0]        w_sel_a;
  logic [31:0]        w_sel_b;
  logic               w_sel_sub;
  logic [NUM_REQ-1:0] w_idx_onehot;
  logic               w_timeout;

  fp_addsub_arbiter_rr_pick #(.N(NUM_REQ)) u_pick (
    .i_req   (i_req),
    .i_ptr   (r_ptr),
    .o_grant (w_pick_grant),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

  always_comb begin
    w_sel_a   = '0;
    w_sel_b   = '0;
    w_sel_sub = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_pick_grant[i]) begin
        w_sel_a   = i_req_a[i*32 +: 32];
        w_sel_b   = i_req_b[i*32 +: 32];
        w_sel_sub = i_req_sub[i];
      end
    end
  end

  always_comb begin
    w_idx_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx_onehot[i] = (r_idx == IW'(i));
    end
  end

  // watchdog is 0 in the first WAIT cycle, so the core gets TIMEOUT+1 WAIT cycles
  assign w_timeout = (r_wdog == WW'(TIMEOUT));
  assign o_busy    = (r_state != ST_IDLE);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state      <= ST_IDLE;
      r_ptr        <= IW'(NUM_REQ - 1);
      r_idx        <= '0;
      r_a_lat      <= '0;
      r_b_lat      <= '0;
      r_wdog       <= '0;
      o_grant      <= '0;
      o_done       <= '0;
      o_result     <= '0;
      o_error      <= 1'b0;
      o_core_start <= 1'b0;
      o_core_a     <= '0;
      o_core_b     <= '0;
    end else begin
      o_grant      <= '0;
      o_done       <= '0;
      o_core_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pick_valid) begin
            o_grant <= w_pick_grant;
            r_idx   <= w_pick_idx;
            r_ptr   <= w_pick_idx;
            r_a_lat <= w_sel_a;
            r_b_lat <= w_sel_sub ? fp_negate(w_sel_b) : w_sel_b;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          o_core_a     <= r_a_lat;
          o_core_b     <= r_b_lat;
          o_core_start <= 1'b1;
          r_wdog       <= '0;
          r_state      <= ST_WAIT;
        end
        ST_WAIT: begin
          // done is issued on the transition so it is visible during the RESP cycle
          if (i_core_done) begin
            o_result <= i_core_result;
            o_error  <= 1'b0;
            o_done   <= w_idx_onehot;
            r_state  <= ST_RESP;
          end else if (w_timeout) begin
            o_result <= FP_QNAN;
            o_error  <= 1'b1;
            o_done   <= w_idx_onehot;
            r_state  <= ST_RESP;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_addsub_arbiter.sv
// tb/tb_fp_addsub_arbiter.sv - randomized self-checking bench with an integer-valued core model
module tb_fp_addsub_arbiter;
  import fp_addsub_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int TO = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req, req_sub;
  logic [32*N-1:0] req_a, req_b;
  logic [N-1:0]    grant, done;
  logic [31:0]     result;
  logic            error, busy, core_start;
  logic [31:0]     core_a, core_b;
  logic            core_done;
  logic [31:0]     core_result;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_grants = 0;
  int n_dones  = 0;
  int core_lat = 5;
  bit core_hang = 1'b0;
  int pend = 0;
  logic [31:0] ca, cb;

  fp_addsub_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_req         (req),
    .i_req_sub     (req_sub),
    .i_req_a       (req_a),
    .i_req_b       (req_b),
    .o_grant       (grant),
    .o_done        (done),
    .o_result      (result),
    .o_error       (error),
    .o_busy        (busy),
    .o_core_start  (core_start),
    .o_core_a      (core_a),
    .o_core_b      (core_b),
    .i_core_done   (core_done),
    .i_core_result (core_result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [31:0] int2fp(input int n);
    int m, msb;
    logic [31:0] mm;
    if (n == 0) return 32'h0;
    m = (n < 0) ? -n : n;
    msb = 0;
    for (int i = 0; i < 31; i++) if (m[i]) msb = i;
    mm = 32'(m) << (23 - msb);
    return {(n < 0), 8'(127 + msb), mm[22:0]};
  endfunction

  function automatic int fp2int(input logic [31:0] f);
    int e, mag;
    e = int'(f[30:23]);
    if (e == 0) return 0;
    mag = int'({9'b1, f[22:0]} >> (150 - e));
    return f[31] ? -mag : mag;
  endfunction

  // external core: adds integer-valued floats after core_lat cycles
  always @(negedge clk) begin
    core_done = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        core_done   = 1'b1;
        core_result = int2fp(fp2int(ca) + fp2int(cb));
      end
    end
    if (core_start && !core_hang) begin
      pend = core_lat;
      ca   = core_a;
      cb   = core_b;
    end
  end

  always @(negedge clk) begin
    if (!rst && grant != '0) n_grants++;
    if (!rst && done != '0) n_dones++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic wait_grant(output int t);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (grant == '0 && n < 100);
    check("grant_seen", {31'b0, grant != '0}, 32'd1);
    t = cyc;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (done == '0 && n < 300);
    check("done_seen", {31'b0, done != '0}, 32'd1);
  endtask

  task automatic finish_op(input int idx, input logic sub, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_res, input int t0, input logic exp_err, input int exp_lat);
    @(negedge clk);
    check("core_start", {31'b0, core_start}, 32'd1);
    check("core_a", core_a, a);
    check("core_b", core_b, b ^ {sub, 31'b0});
    wait_done();
    check("done_idx", {28'b0, done}, 32'(1 << idx));
    check("latency", 32'(cyc - t0), 32'(exp_lat));
    check("result", result, exp_res);
    check("error", {31'b0, error}, {31'b0, exp_err});
  endtask

  task automatic run_op(input int idx, input logic sub, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res);
    int t0;
    req_a[idx*32 +: 32] = a;
    req_b[idx*32 +: 32] = b;
    req_sub[idx] = sub;
    req[idx] = 1'b1;
    wait_grant(t0);
    check("grant", {28'b0, grant}, 32'(1 << idx));
    req[idx] = 1'b0;
    req_a[idx*32 +: 32] = $urandom();
    req_b[idx*32 +: 32] = $urandom();
    finish_op(idx, sub, a, b, exp_res, t0, 1'b0, 2 + core_lat);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_grant_done"}, {24'b0, grant, done}, 32'd0);
    check({tag, "_result"}, result, 32'd0);
    check({tag, "_flags"}, {29'b0, error, busy, core_start}, 32'd0);
    check({tag, "_core_a"}, core_a, 32'd0);
    check({tag, "_core_b"}, core_b, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    int xs[N], ys[N], t0, g0, d0, idx, x, y;
    logic subs[N];
    logic s;
    rst = 1'b1; req = '0; req_sub = '0; req_a = '0; req_b = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    core_lat = 5;
    run_op(0, 1'b0, 32'h40400000, FP_ONE, 32'h40800000);
    run_op(2, 1'b1, int2fp(5), FP_ONE, int2fp(4));

    repeat (12) begin
      idx = int'($urandom_range(N - 1));
      s = 1'($urandom_range(1));
      x = int'($urandom_range(2000)) - 1000;
      y = int'($urandom_range(2000)) - 1000;
      core_lat = int'($urandom_range(8, 1));
      run_op(idx, s, int2fp(x), int2fp(y), int2fp(s ? x - y : x + y));
    end

    // contention: all requesters held high, grants must rotate from 0
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    core_lat = 2;
    for (int i = 0; i < N; i++) begin
      xs[i] = int'($urandom_range(200)) - 100;
      ys[i] = int'($urandom_range(200)) - 100;
      subs[i] = 1'($urandom_range(1));
      req_a[i*32 +: 32] = int2fp(xs[i]);
      req_b[i*32 +: 32] = int2fp(ys[i]);
      req_sub[i] = subs[i];
    end
    req = '1;
    for (int k = 0; k < 2 * N; k++) begin
      idx = k % N;
      wait_grant(t0);
      check("rr_grant", {28'b0, grant}, 32'(1 << idx));
      if (k == 2 * N - 1) req = '0;
      finish_op(idx, subs[idx], int2fp(xs[idx]), int2fp(ys[idx]),
                int2fp(subs[idx] ? xs[idx] - ys[idx] : xs[idx] + ys[idx]), t0, 1'b0, 2 + core_lat);
    end
    g0 = n_grants;
    repeat (6) @(negedge clk);
    check("rr_no_extra_grant", 32'(n_grants), 32'(g0));

    // hung core -> qNaN error response, then normal service
    core_hang = 1'b1;
    req_a[3*32 +: 32] = int2fp(7);
    req_b[3*32 +: 32] = int2fp(2);
    req_sub[3] = 1'b0;
    req[3] = 1'b1;
    wait_grant(t0);
    check("to_grant", {28'b0, grant}, 32'd8);
    req[3] = 1'b0;
    finish_op(3, 1'b0, int2fp(7), int2fp(2), FP_QNAN, t0, 1'b1, TO + 2);
    core_hang = 1'b0;
    core_lat = 5;
    run_op(3, 1'b1, int2fp(7), int2fp(2), int2fp(5));

    // late drop: req deasserted right after grant still completes, no re-grant
    run_op(1, 1'b0, int2fp(-9), int2fp(4), int2fp(-5));
    g0 = n_grants;
    repeat (10) @(negedge clk);
    check("drop_no_regrant", 32'(n_grants), 32'(g0));

    // reset two cycles after core_start
    core_lat = 10;
    req_a[31:0] = int2fp(11);
    req_b[31:0] = int2fp(3);
    req_sub[0] = 1'b0;
    req[0] = 1'b1;
    wait_grant(t0);
    check("rw_grant", {28'b0, grant}, 32'd1);
    req[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    d0 = n_dones;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("late_done_ignored", 32'(n_dones), 32'(d0));
    check("idle_after_reset", {31'b0, busy}, 32'd0);
    core_lat = 3;
    req_a[31:0] = int2fp(20);  req_b[31:0] = int2fp(6);  req_sub[0] = 1'b1;
    req_a[63:32] = int2fp(1);  req_b[63:32] = int2fp(1); req_sub[1] = 1'b0;
    req[1:0] = 2'b11;
    wait_grant(t0);
    check("post_rst_first", {28'b0, grant}, 32'd1);
    req[0] = 1'b0;
    finish_op(0, 1'b1, int2fp(20), int2fp(6), int2fp(14), t0, 1'b0, 2 + core_lat);
    wait_grant(t0);
    check("post_rst_second", {28'b0, grant}, 32'd2);
    req[1] = 1'b0;
    finish_op(1, 1'b0, int2fp(1), int2fp(1), int2fp(2), t0, 1'b0, 2 + core_lat);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
